// File: rtl/apb4_slave_regif.sv
`default_nettype none
// ============================================================================
//  Module      : apb4_slave_regif
//  Description : APB4 slave front end for a bank of NUM_REGS 32-bit registers.
//                Decodes PADDR[11:0] against ADDR_OFFSET + 4*i, optionally
//                inserts WAIT_CYCLES wait states, and issues one-cycle
//                read/write enable pulses to the register bank.
//                Optional macro APB4_SLV_PSTRB_EN: latch PSTRB onto w_strb
//                and treat a zero-strobe write as a slave error.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb4_slave_regif #(
    parameter int                     NUM_REGS    = 4,
    parameter logic [11:0]            ADDR_OFFSET = 12'h000,
    parameter int                     WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0]    RO_MASK     = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               PADDR,
    input  logic [31:0]               PWDATA,
    input  logic [3:0]                PSTRB,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_REGS*32-1:0]    read_data,
    output logic [NUM_REGS-1:0]       w_enable,
    output logic [NUM_REGS-1:0]       r_enable,
    output logic [31:0]               w_data,
    output logic [3:0]                w_strb
);

    localparam int          IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0]  c_wait_load = 4'(WAIT_CYCLES);
    localparam logic [31:0] c_err_data  = 32'hBAD1BAD1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_write;
    logic [3:0]         r_cnt;

    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_ro;
    logic               w_err;
    logic [NUM_REGS-1:0] w_onehot;
    logic [31:0]        w_rd_sel;

`ifdef APB4_SLV_PSTRB_EN
    logic [3:0]         r_strb;
    logic               w_unused_bits;
    assign w_unused_bits = ^PADDR[31:12];
`else
    logic               w_unused_bits;
    assign w_unused_bits = ^{PADDR[31:12], PSTRB};
`endif

    // Address decode and error classification for the setup phase; the
    // ascending scan lets the highest matching index win.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_ro      = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (PADDR[11:0] == (ADDR_OFFSET + 12'(4 * i))) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_hit_idx == IDX_W'(i)) begin
                w_ro = RO_MASK[i];
            end
        end
        w_err = !w_hit || (PADDR[1:0] != 2'b00) || (PWRITE && w_ro);
`ifdef APB4_SLV_PSTRB_EN
        w_err = w_err || (PWRITE && (PSTRB == 4'h0));
`endif
    end

    // Transfer state machine: latch the request at setup, count wait states,
    // then present a single ACCESS or ERROR completion cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_cnt   <= 4'd0;
`ifdef APB4_SLV_PSTRB_EN
            r_strb  <= 4'h0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        r_idx   <= w_hit_idx;
                        r_write <= PWRITE;
                        r_cnt   <= c_wait_load;
`ifdef APB4_SLV_PSTRB_EN
                        r_strb  <= PSTRB;
`endif
                        if (w_err) begin
                            r_state <= ST_ERROR;
                        end else if (c_wait_load != 4'd0) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!PSEL) begin
                        // Master abandoned the transfer: drop it silently.
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt <= 4'd1) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                    end
                end
                ST_ACCESS: r_state <= ST_IDLE;
                ST_ERROR:  r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Completion-phase outputs decoded from the registered state and index.
    always_comb begin
        w_onehot = '0;
        w_rd_sel = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_onehot[i] = 1'b1;
                w_rd_sel    = read_data[32*i +: 32];
            end
        end
        PREADY   = (r_state == ST_ACCESS) || (r_state == ST_ERROR);
        PSLVERR  = (r_state == ST_ERROR);
        PRDATA   = 32'h0;
        w_enable = '0;
        r_enable = '0;
        if (r_state == ST_ACCESS) begin
            if (r_write) begin
                w_enable = w_onehot;
            end else begin
                r_enable = w_onehot;
                PRDATA   = w_rd_sel;
            end
        end else if (r_state == ST_ERROR) begin
            PRDATA = c_err_data;
        end
    end

    assign w_data = PWDATA;

`ifdef APB4_SLV_PSTRB_EN
    assign w_strb = r_strb;
`else
    assign w_strb = 4'hF;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb4_slave_regif.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb4_slave_regif
//  Description : Scoreboard bench for apb4_slave_regif. Three instances
//                (WAIT_CYCLES 0/3/5) share the APB bus with private PSEL
//                lines; the driver queues expected completions and a
//                negedge monitor checks every completion and quiet cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb4_slave_regif;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [31:0]  paddr, pwdata;
    logic [3:0]   pstrb;
    logic         pwrite, penable;
    logic [2:0]   psel;
    logic [127:0] rd_bus;

    logic [2:0]   pready, pslverr;
    logic [31:0]  prdata [3];
    logic [3:0]   wen [3];
    logic [3:0]   ren [3];
    logic [3:0]   wstrb [3];
    logic [31:0]  wdo [3];

    apb4_slave_regif #(.NUM_REGS(4), .ADDR_OFFSET(12'h000), .WAIT_CYCLES(0), .RO_MASK(4'b0001)) u_a (
        .clk(clk), .rst(rst), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PWRITE(pwrite),
        .PSEL(psel[0]), .PENABLE(penable), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
        .read_data(rd_bus), .w_enable(wen[0]), .r_enable(ren[0]), .w_data(wdo[0]), .w_strb(wstrb[0]));

    apb4_slave_regif #(.NUM_REGS(4), .ADDR_OFFSET(12'h000), .WAIT_CYCLES(3), .RO_MASK(4'b0000)) u_b (
        .clk(clk), .rst(rst), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PWRITE(pwrite),
        .PSEL(psel[1]), .PENABLE(penable), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
        .read_data(rd_bus), .w_enable(wen[1]), .r_enable(ren[1]), .w_data(wdo[1]), .w_strb(wstrb[1]));

    apb4_slave_regif #(.NUM_REGS(4), .ADDR_OFFSET(12'h000), .WAIT_CYCLES(5), .RO_MASK(4'b0000)) u_c (
        .clk(clk), .rst(rst), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PWRITE(pwrite),
        .PSEL(psel[2]), .PENABLE(penable), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]),
        .read_data(rd_bus), .w_enable(wen[2]), .r_enable(ren[2]), .w_data(wdo[2]), .w_strb(wstrb[2]));

    typedef struct {
        int          dut;
        logic        slverr;
        logic [31:0] prdata;
        logic [3:0]  wen;
        logic [3:0]  ren;
        logic [3:0]  wstrb;
        logic        chk_strb;
        logic [31:0] wdata;
        int          lows;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   total = 0;
    int   bad   = 0;
    int   lows [3];
    bit   mon_on = 1'b0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // lows = cycles PREADY stays low with PSEL high, including the setup cycle
    function automatic exp_t e_wr(int k, int idx, logic [31:0] d, logic [3:0] ws, int lw);
        e_wr = '{k, 1'b0, 32'h0, 4'(1 << idx), 4'h0, ws, 1'b1, d, lw};
    endfunction

    function automatic exp_t e_rd(int k, int idx, logic [31:0] rdv, logic [31:0] d, int lw);
        e_rd = '{k, 1'b0, rdv, 4'h0, 4'(1 << idx), 4'h0, 1'b0, d, lw};
    endfunction

    function automatic exp_t e_er(int k, logic [31:0] d);
        e_er = '{k, 1'b1, 32'hBAD1BAD1, 4'h0, 4'h0, 4'h0, 1'b0, d, 1};
    endfunction

    // Monitor: every completion pops the scoreboard; every other cycle must be quiet.
    initial begin
        for (int k = 0; k < 3; k++) lows[k] = 0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                for (int k = 0; k < 3; k++) begin
                    if (pready[k]) begin
                        if (sb.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_pready: dut %0d got PREADY=1 expected no completion at %0t", k, $time);
                        end else begin
                            me = sb.pop_front();
                            check("dut_id",  k,            me.dut);
                            check("pslverr", {31'b0, pslverr[k]}, {31'b0, me.slverr});
                            check("prdata",  prdata[k],    me.prdata);
                            check("w_enable", {28'b0, wen[k]}, {28'b0, me.wen});
                            check("r_enable", {28'b0, ren[k]}, {28'b0, me.ren});
                            check("w_data",  wdo[k],       me.wdata);
                            check("wait_lows", lows[k],    me.lows);
                            if (me.chk_strb) check("w_strb", {28'b0, wstrb[k]}, {28'b0, me.wstrb});
                        end
                        lows[k] = 0;
                    end else begin
                        check("idle_quiet", prdata[k] | {23'b0, pslverr[k], wen[k], ren[k]}, 32'h0);
                        if (psel[k]) lows[k]++;
                        else         lows[k] = 0;
                    end
                end
            end
        end
    end

    // One complete APB transfer on instance k; expectation queued up front.
    task automatic xfer(int k, logic [31:0] a, logic w, logic [31:0] d, logic [3:0] s, exp_t e);
        int n;
        sb.push_back(e);
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        pstrb   = s;
        penable = 1'b0;
        psel    = 3'(1 << k);
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        while (!pready[k] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!pready[k]) begin
            total++;
            bad++;
            $display("FAIL timeout: dut %0d PREADY=0 after %0d cycles expected 1", k, n);
        end
        @(posedge clk); #1;
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        pstrb   = 4'hF;
        pwrite  = 1'b0;
        penable = 1'b0;
        psel    = 3'b000;
        rd_bus  = {32'h44443333, 32'hCAFEF00D, 32'h22221111, 32'h11110000};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Zero-wait instance, back-to-back transfers
        xfer(0, 32'h004, 1'b1, 32'h12345678, 4'hF, e_wr(0, 1, 32'h12345678, 4'hF, 1));
        xfer(0, 32'h008, 1'b0, 32'h0,        4'hF, e_rd(0, 2, 32'hCAFEF00D, 32'h0, 1));
        xfer(0, 32'h000, 1'b1, 32'hDEADBEEF, 4'hF, e_er(0, 32'hDEADBEEF));
        xfer(0, 32'h000, 1'b0, 32'h0,        4'hF, e_rd(0, 0, 32'h11110000, 32'h0, 1));
        xfer(0, 32'h040, 1'b0, 32'h0,        4'hF, e_er(0, 32'h0));
        xfer(0, 32'h006, 1'b1, 32'h00000077, 4'hF, e_er(0, 32'h00000077));
        xfer(0, 32'h00C, 1'b0, 32'h0,        4'hF, e_rd(0, 3, 32'h44443333, 32'h0, 1));
`ifdef APB4_SLV_PSTRB_EN
        xfer(0, 32'h00C, 1'b1, 32'hA5A5A5A5, 4'b0101, e_wr(0, 3, 32'hA5A5A5A5, 4'b0101, 1));
        xfer(0, 32'h00C, 1'b1, 32'h5A5A5A5A, 4'b0000, e_er(0, 32'h5A5A5A5A));
`else
        xfer(0, 32'h00C, 1'b1, 32'hA5A5A5A5, 4'b0101, e_wr(0, 3, 32'hA5A5A5A5, 4'hF, 1));
        xfer(0, 32'h00C, 1'b1, 32'h5A5A5A5A, 4'b0000, e_wr(0, 3, 32'h5A5A5A5A, 4'hF, 1));
`endif
        repeat (2) @(posedge clk);
        #1;

        // Three-wait instance
        xfer(1, 32'h008, 1'b0, 32'h0,        4'hF, e_rd(1, 2, 32'hCAFEF00D, 32'h0, 4));
        xfer(1, 32'h004, 1'b1, 32'h0BADCAFE, 4'hF, e_wr(1, 1, 32'h0BADCAFE, 4'hF, 4));
        xfer(1, 32'h040, 1'b0, 32'h0,        4'hF, e_er(1, 32'h0));
        repeat (2) @(posedge clk);
        #1;

        // Five-wait instance: reset during the second WAIT cycle
        paddr = 32'h004; pwrite = 1'b0; penable = 1'b0; psel = 3'b100;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);   // PSEL+PENABLE while IDLE must be ignored
        #1;
        psel = 3'b000; penable = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Five-wait instance: PSEL withdrawn during WAIT
        paddr = 32'h008; pwrite = 1'b1; pwdata = 32'h99999999; penable = 1'b0; psel = 3'b100;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        psel = 3'b000; penable = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Five-wait instance still serves a normal transfer afterwards
        xfer(2, 32'h004, 1'b0, 32'h0, 4'hF, e_rd(2, 1, 32'h22221111, 32'h0, 6));

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
